// File: rtl/pb_ram_arbiter_if.sv
// Signal bundle between the two requester port-decode blocks, the RAM pins and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface pb_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic                  busy;
  logic                  grant;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_dout,
    output ack0, rdata0, ack1, rdata1,
    output ram_en, ram_we, ram_addr, ram_din,
    output busy, grant
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_dout,
    input  ack0, rdata0, ack1, rdata1,
    input  ram_en, ram_we, ram_addr, ram_din,
    input  busy, grant
  );
endinterface

// File: rtl/pb_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read latency) between two
// PicoBlaze-side requesters using a four-phase req/ack handshake.
module pb_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  pb_ram_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic                  armed0_q, armed0_d;
  logic                  armed1_q, armed1_d;
  logic                  grant_q, grant_d;
  logic                  we_l_q, we_l_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic elig0, elig1, pick;

  assign elig0 = bus.req0 & armed0_q;
  assign elig1 = bus.req1 & armed1_q;
  // On a tie serve the requester not served last.
  assign pick  = (elig0 & elig1) ? ~grant_q : elig1;

  always_comb begin
    state_d    = state_q;
    armed0_d   = armed0_q | ~bus.req0;
    armed1_d   = armed1_q | ~bus.req1;
    grant_d    = grant_q;
    we_l_d     = we_l_q;
    ram_en_d   = ram_en_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          state_d  = StIssue;
          grant_d  = pick;
          ram_en_d = 1'b1;
          if (pick) begin
            armed1_d   = 1'b0;
            we_l_d     = bus.we1;
            ram_we_d   = bus.we1;
            ram_addr_d = bus.addr1;
            ram_din_d  = bus.wdata1;
          end else begin
            armed0_d   = 1'b0;
            we_l_d     = bus.we0;
            ram_we_d   = bus.we0;
            ram_addr_d = bus.addr0;
            ram_din_d  = bus.wdata0;
          end
        end
      end
      StIssue: begin
        state_d    = StWait;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = '0;
        ram_din_d  = '0;
      end
      StWait: begin
        state_d = StIdle;
        if (grant_q) begin
          ack1_d = 1'b1;
          if (!we_l_q) rdata1_d = bus.ram_dout;
        end else begin
          ack0_d = 1'b1;
          if (!we_l_q) rdata0_d = bus.ram_dout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      armed0_q   <= 1'b1;
      armed1_q   <= 1'b1;
      grant_q    <= 1'b1;
      we_l_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      armed0_q   <= armed0_d;
      armed1_q   <= armed1_d;
      grant_q    <= grant_d;
      we_l_q     <= we_l_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_pb_ram_arbiter.sv
// Directed bench for pb_ram_arbiter with a behavioural 1-cycle-latency RAM on the far side.
module tb_pb_ram_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   overlap;

  pb_ram_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  pb_ram_arbiter #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM, contents preset to 0x00,0x11,...,0xFF.
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
  end
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  always @(negedge clk) begin
    if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) overlap++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One complete access by requester `who`, checking the fixed T+1 / T+3 timing.
  task automatic access(input string tag, input bit who, input bit we,
                        input logic [3:0] a, input logic [7:0] d);
    if (who) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
    step();
    chk({tag, "_en"}, 32'(bus.ram_en), 1);
    chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(a));
    step();
    step();
    chk({tag, "_ack"}, 32'(who ? bus.ack1 : bus.ack0), 1);
    chk({tag, "_other_ack"}, 32'(who ? bus.ack0 : bus.ack1), 0);
    if (who) bus.req1 = 1'b0;
    else     bus.req0 = 1'b0;
    step();
  endtask

  initial begin
    int n_ack;
    int n_busy;
    errors  = 0;
    checks  = 0;
    overlap = 0;
    bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    do_reset();

    // Reset state
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant), 1);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_din", 32'(bus.ram_din), 0);

    // 1: write 0xA5 to addr 3, then read it back
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
    step();
    chk("t1_issue_en", 32'(bus.ram_en), 1);
    chk("t1_issue_we", 32'(bus.ram_we), 1);
    chk("t1_issue_addr", 32'(bus.ram_addr), 3);
    chk("t1_issue_din", 32'(bus.ram_din), 'hA5);
    chk("t1_issue_busy", 32'(bus.busy), 1);
    step();
    chk("t1_wait_en", 32'(bus.ram_en), 0);
    chk("t1_wait_ack0", 32'(bus.ack0), 0);
    step();
    chk("t1_wr_ack0", 32'(bus.ack0), 1);
    chk("t1_wr_busy", 32'(bus.busy), 0);
    chk("t1_wr_rdata0", 32'(bus.rdata0), 0);
    bus.req0 = 1'b0;
    step();
    chk("t1_ack0_pulse", 32'(bus.ack0), 0);
    access("t1_rd", 1'b0, 1'b0, 4'd3, 8'h00);
    chk("t1_rdata0", 32'(bus.rdata0), 'hA5);

    // 2: simultaneous requests after reset
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
    step();
    chk("t2_first_grant", 32'(bus.grant), 0);
    chk("t2_first_addr", 32'(bus.ram_addr), 1);
    step();
    step();
    chk("t2_ack0", 32'(bus.ack0), 1);
    chk("t2_ack1_early", 32'(bus.ack1), 0);
    chk("t2_rdata0", 32'(bus.rdata0), 'h11);
    bus.req0 = 1'b0;
    step();
    chk("t2_second_grant", 32'(bus.grant), 1);
    chk("t2_second_addr", 32'(bus.ram_addr), 2);
    step();
    chk("t2_ack1_t5", 32'(bus.ack1), 0);
    step();
    chk("t2_ack1", 32'(bus.ack1), 1);
    chk("t2_rdata1", 32'(bus.rdata1), 'h22);
    bus.req1 = 1'b0;
    step();

    // 3: both requesters stay eligible at every decision; grants must alternate
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd8;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd9;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t3_grant%0d", k), 32'(bus.grant), 32'(k % 2));
      if (k % 2 == 1) bus.req1 = 1'b0;
      else            bus.req0 = 1'b0;
      step();
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      step();
      chk($sformatf("t3_ack%0d", k), 32'((k % 2 == 1) ? bus.ack1 : bus.ack0), 1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
    step();
    chk("t3_rdata0", 32'(bus.rdata0), 'h88);
    chk("t3_rdata1", 32'(bus.rdata1), 'h99);

    // 4: req1 held after ack must not be served again until it drops
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd4;
    step();
    step();
    step();
    chk("t4_first_ack1", 32'(bus.ack1), 1);
    n_ack  = 0;
    n_busy = 0;
    repeat (20) begin
      step();
      if (bus.ack1) n_ack++;
      if (bus.busy) n_busy++;
    end
    chk("t4_held_acks", 32'(n_ack), 0);
    chk("t4_held_busy", 32'(n_busy), 0);
    bus.req1 = 1'b0;
    step();
    bus.req1 = 1'b1;
    step();
    chk("t4_rearm_busy", 32'(bus.busy), 1);
    chk("t4_rearm_grant", 32'(bus.grant), 1);
    step();
    step();
    chk("t4_rearm_ack1", 32'(bus.ack1), 1);
    chk("t4_rdata1", 32'(bus.rdata1), 'h44);
    bus.req1 = 1'b0;
    step();

    // 5: reset during WAIT of a requester-1 read
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd6;
    step();
    step();
    chk("t5_wait_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    step();
    chk("t5_ack1", 32'(bus.ack1), 0);
    chk("t5_rdata1", 32'(bus.rdata1), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_ram_en", 32'(bus.ram_en), 0);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd0;
    step();
    chk("t5_next_grant", 32'(bus.grant), 0);
    step();
    step();
    chk("t5_next_ack0", 32'(bus.ack0), 1);
    chk("t5_next_ack1", 32'(bus.ack1), 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();

    // 6: address/data changes after grant do not affect the access in flight
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 8'h3C;
    step();
    bus.addr0  = 4'd7;
    bus.wdata0 = 8'hFF;
    chk("t6_issue_addr", 32'(bus.ram_addr), 5);
    chk("t6_issue_din", 32'(bus.ram_din), 'h3C);
    step();
    step();
    chk("t6_wr_ack0", 32'(bus.ack0), 1);
    chk("t6_wr_rdata0", 32'(bus.rdata0), 0);
    bus.req0 = 1'b0;
    step();
    access("t6_rd5", 1'b0, 1'b0, 4'd5, 8'h00);
    chk("t6_rdata_addr5", 32'(bus.rdata0), 'h3C);
    access("t6_rd7", 1'b0, 1'b0, 4'd7, 8'h00);
    chk("t6_rdata_addr7", 32'(bus.rdata0), 'h77);

    chk("ack_overlap", 32'(overlap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pb_ram_arbiter.md
Name: pb_ram_arbiter

Overview:
- Shares one single-port block RAM (1-cycle read latency) between two PicoBlaze-side requesters, e.g. the cipher core and the random-number core.
- Round-robin arbitration, one access per grant, fixed latency.
- Four-phase req/ack handshake, so firmware can poll ack through an input port and drop req through an output port.
- Sits between the two cores' port-decode logic and the RAM's ena/wea/addra/dina/douta pins.

Parameters:
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM data width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request (level)
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_WIDTH  requester 0 address
wdata0  in  DATA_WIDTH  requester 0 write data
ack0  out  1  requester 0 access complete, 1-cycle pulse
rdata0  out  DATA_WIDTH  requester 0 read data, held until its next read
req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1
ram_en  out  1  RAM enable (ena)
ram_we  out  1  RAM write enable (wea)
ram_addr  out  ADDR_WIDTH  RAM address
ram_din  out  DATA_WIDTH  RAM write data
ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en
busy  out  1  high in any state other than IDLE
grant  out  1  index of the requester being served; last served while IDLE

Behaviour:
- Reset (synchronous, active-high), applied in any state:
  - state = IDLE.
  - ram_en = ram_we = 0; ram_addr = ram_din = 0.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0; busy = 0; grant = 1, so requester 0 has priority first.
  - armed0 = armed1 = 1.
  - Any in-flight access is abandoned: no ack, rdata unchanged from reset value.
  - A RAM write already issued in the same cycle completes in the RAM; this is accepted.
- Eligibility: requester n is eligible when reqn = 1 and armedn = 1.
  - armedn is cleared when n is granted.
  - armedn is set in any cycle where reqn = 0.
  - Effect: requester n is not served again until it has dropped req at least once after its ack.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: if no requester is eligible, stay.
    - If exactly one is eligible, grant it.
    - If both are eligible, grant the one opposite the current grant value (round-robin).
    - On grant, latch the granted we/addr/wdata into internal registers, update grant, go to ISSUE.
  - ISSUE (1 cycle): ram_en = 1, ram_we = latched we, ram_addr/ram_din = latched values; go to WAIT.
  - WAIT (1 cycle): ram_en = 0. If the access is a read, rdata[grant] <= ram_dout. ack[grant] <= 1, registered. Go to IDLE.
  - ram_en, ram_we, ram_addr and ram_din are registered outputs, valid exactly during ISSUE and deasserted otherwise.
- Timing: eligible req sampled in IDLE at cycle T.
  - ISSUE at T+1, WAIT at T+2.
  - ack pulse and updated rdata visible at T+3.
  - FSM is back in IDLE at T+3, so a new grant can be made at T+3.
  - Minimum spacing between accesses is 3 cycles.
- Writes take the same path and latency as reads; rdata is unchanged on writes.
- Requester inputs are ignored except in IDLE. Changes to we/addr/wdata after grant do not affect the access in flight.
- req dropped before ack does not cancel a granted access; ack is still pulsed.
- ack0 and ack1 are never high in the same cycle. Each is high for exactly one cycle per access.
- Fairness: with both requesters continuously eligible, grants strictly alternate; no starvation beyond one access.

Test Plan:
1. Write, then read back: after reset, req0 with we0=1, addr0=3, wdata0=0xA5.
   - Required: ram_en=1, ram_we=1 at T+1; ack0 at T+3.
   - Drop req0, then read addr0=3: rdata0 = 0xA5 with ack0 at T+3; ack1 stays 0.
2. Simultaneous requests: req0 and req1 raised in the same cycle after reset.
   - Required: requester 0 is granted first and acked at T+3.
   - Requester 1 is granted at T+3 and acked at T+6.
3. Round-robin under load: both reqs toggled per the handshake for 6 accesses.
   - Required: grant sequence 0,1,0,1,0,1; no ack overlap.
4. Re-arm rule: req1 held high for 20 cycles after its ack, req0 low.
   - Required: exactly one ack1 and no second access.
   - Then req1 low for 1 cycle, then high: a second access is made.
5. Reset mid-operation: reset asserted during WAIT of a read by requester 1.
   - Required: next cycle ack1=0, rdata1=0, busy=0, ram_en=0.
   - A subsequent simultaneous request is granted to requester 0.
6. Input change after grant: req0 write to addr 5 with data 0x3C; addr0 changed to 7 during ISSUE.
   - Required: ram_addr=5 in ISSUE.
   - A later read of addr 5 returns 0x3C; addr 7 is unchanged.
